// File: rtl/fir_mac_sequencer.sv
// Folded FIR controller. A single signed multiplier and accumulator are
// time-shared over NTAPS taps per accepted sample. The block owns the circular
// sample history, the run-time writable coefficient bank and both valid/ready
// handshakes. One result is produced every NTAPS+2 cycles at best.
module fir_mac_sequencer #(
    parameter int NTAPS = 27,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACCW  = 32,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,      // active-high asynchronous reset
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] out_data,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic signed [CW-1:0]   cfg_data,
    output logic                   cfg_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    localparam int              PW   = DW + CW;
    localparam logic [AW-1:0]   LAST = AW'(NTAPS - 1);

    state_t                  state;
    logic signed [CW-1:0]    coef [NTAPS];
    logic signed [DW-1:0]    hist [NTAPS];
    logic [AW-1:0]           wr_ptr;     // slot that receives the next sample
    logic [AW-1:0]           rd_ptr;     // walks backwards from the newest sample
    logic [AW-1:0]           tap;        // coefficient index k
    logic signed [ACCW-1:0]  acc;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_next;
    logic                    cfg_ok;
    logic                    accept;

    // Coefficient writes are only legal while idle and inside the tap range.
    assign cfg_ok = cfg_we && (state == S_IDLE) && (cfg_addr <= LAST);
    assign accept = in_valid && (state == S_IDLE);

    // Multiply-accumulate datapath: full-width signed product, wrapping sum.
    always_comb begin
        prod     = PW'(coef[tap]) * PW'(hist[rd_ptr]);
        acc_next = acc + ACCW'(prod);
    end

    // Coefficient bank and sample history; a new coefficient written on the
    // accepting edge is already visible to the first MAC cycle of that sample.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: both arrays are reset because the filter must start from a
            // zero history and zero taps; this costs a reset net per bit.
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
                hist[i] <= '0;
            end
        end else begin
            if (cfg_ok)
                coef[cfg_addr] <= cfg_data;
            if (accept)
                hist[wr_ptr] <= in_data;
        end
    end

    // Rejected configuration writes produce a one-cycle error pulse.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            cfg_err <= 1'b0;
        else
            cfg_err <= cfg_we && !cfg_ok;
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tap       <= '0;
            acc       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        rd_ptr   <= wr_ptr;
                        tap      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc    <= acc_next;
                    tap    <= tap + AW'(1);
                    rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - AW'(1);
                    if (tap == LAST) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: scenario tasks against a convolution model
// that keeps the list of accepted samples and the current coefficient values.
module tb_fir_mac_sequencer;

    localparam int N = 27;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: coefficient values and samples accepted since reset.
    int coef_m [N];
    int samp_q [$];

    fir_mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // y[n] = sum_k h[k] * x[n-k], missing past samples are zero, wrap to 32 bits.
    function automatic logic [31:0] model_out();
        longint s = 0;
        int     sz = samp_q.size();
        for (int k = 0; k < N; k++)
            if (k < sz)
                s += longint'(coef_m[k]) * longint'(samp_q[sz - 1 - k]);
        return s[31:0];
    endfunction

    task automatic model_push(input int x);
        logic signed [15:0] v;
        v = x[15:0];
        samp_q.push_back(int'(v));
        if (samp_q.size() > N)
            void'(samp_q.pop_front());
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        foreach (coef_m[i]) coef_m[i] = 0;
        samp_q.delete();
    endtask

    // Unchecked coefficient write while idle; keeps the model in step.
    task automatic cfg_write(input int addr, input int data);
        logic signed [15:0] d;
        d        = data[15:0];
        cfg_we   = 1'b1;
        cfg_addr = addr[4:0];
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr < N)
            coef_m[addr] = int'(d);
    endtask

    // Waits for in_ready, offers one sample and returns at the negedge after acceptance.
    task automatic start_sample(input int x);
        int g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL in_ready_timeout: got in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = x[15:0];
        model_push(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency/value/status, holds back-pressure,
    // then releases it and checks the return to idle.
    task automatic wait_result(input string name, input int exp_lat, input int hold,
                               input logic [31:0] want);
        int lat = 0;
        bit unstable = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        total++;
        if (out_data !== want) begin
            bad++;
            $display("FAIL %s data: got %h want %h", name, out_data, want);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s status: got in_ready=%b busy=%b want 0 1", name, in_ready, busy);
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== want || in_ready !== 1'b0)
                    unstable = 1'b1;
            end
            total++;
            if (unstable) begin
                bad++;
                $display("FAIL %s hold: got unstable output want stable %h", name, want);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got out_valid=%b busy=%b cfg_err=%b want 0 0 0",
                     out_valid, busy, cfg_err);
        end
        total++;
        if (out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
    endtask

    // h[k]=k+1, one impulse then zeros: outputs walk 1..27 then 0.
    task automatic test_impulse();
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, k + 1);
        for (int i = 0; i <= N; i++) begin
            start_sample(i == 0 ? 1 : 0);
            wait_result("impulse", N, 0, (i < N) ? 32'(i + 1) : 32'h0);
        end
    endtask

    // Symmetric low-pass with constant input 100; steady state then back-pressure.
    task automatic test_symmetric();
        int h [14] = '{-255, -260, -312, -288, -144, 153, 616, 1233, 1963, 2739,
                       3474, 4081, 4481, 4620};
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, (k < 14) ? h[k] : h[N - 1 - k]);
        for (int i = 0; i < 30; i++) begin
            start_sample(100);
            wait_result("symmetric", N, 0, (i >= N - 1) ? 32'd3958200 : model_out());
        end
        start_sample(100);
        wait_result("backpressure", N, 10, 32'd3958200);
    endtask

    // Rejected writes: during MAC and out-of-range address in idle.
    task automatic test_cfg_reject();
        logic [31:0] want;
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, $urandom_range(0, 65535));
        cfg_write(3, 1234);
        start_sample($urandom_range(0, 65535));
        want     = model_out();
        cfg_we   = 1'b1;
        cfg_addr = 5'd3;
        cfg_data = 16'd7;
        @(negedge clk);
        cfg_we = 1'b0;
        total++;
        if (cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL cfg_err_mac: got %b want 1", cfg_err);
        end
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_pulse: got %b want 0", cfg_err);
        end
        wait_result("cfg_mac_drop", N - 2, 0, want);
        cfg_write(27, 5);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL cfg_err_range: got %b want 1", cfg_err);
        end
        cfg_write(26, 9);
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_legal: got %b want 0", cfg_err);
        end
        start_sample($urandom_range(0, 65535));
        wait_result("cfg_after", N, 0, model_out());
    endtask

    // Extreme negative operands: 27 * 2^30 wraps to 0xC0000000.
    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, -32768);
        for (int i = 0; i < N + 1; i++) begin
            start_sample(-32768);
            wait_result("wrap", N, 0, (i >= N - 1) ? 32'hC000_0000 : model_out());
        end
    endtask

    // Coefficient write and sample accepted on the same edge use the new value.
    task automatic test_same_edge();
        logic signed [15:0] d;
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, $urandom_range(0, 65535));
        for (int r = 0; r < 4; r++) begin
            int a;
            a = $urandom_range(0, N - 1);
            d = 16'($urandom);
            cfg_we   = 1'b1;
            cfg_addr = a[4:0];
            cfg_data = d;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            coef_m[a] = int'(d);
            model_push(int'($signed(in_data)));
            @(negedge clk);
            cfg_we   = 1'b0;
            in_valid = 1'b0;
            total++;
            if (cfg_err !== 1'b0) begin
                bad++;
                $display("FAIL same_edge_err: got %b want 0", cfg_err);
            end
            wait_result("same_edge", N, 0, model_out());
        end
    endtask

    // Continuous traffic with out_ready tied high: period must be N+2 cycles.
    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        int last_acc = -1;
        int n_acc = 0;
        int n_out = 0;
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, $urandom_range(0, 65535));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 8 * (N + 2) && n_out < 6; cyc++) begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious: got %h want no output", out_data);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        bad++;
                        $display("FAIL b2b_data: got %h want %h", out_data, w);
                    end
                end
                n_out++;
            end
            if (in_ready && n_acc < 6) begin
                in_data = 16'($urandom);
                model_push(int'($signed(in_data)));
                exp_q.push_back(model_out());
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc !== N + 2) begin
                        bad++;
                        $display("FAIL b2b_period: got %0d want %0d", cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end else if (n_acc >= 6) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (n_out !== 6) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 6", n_out);
        end
    endtask

    // Reset in the middle of MAC abandons the sample and clears taps and history.
    task automatic test_reset_mid_mac();
        do_reset();
        for (int k = 0; k < N; k++) cfg_write(k, k + 1);
        start_sample(5);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        foreach (coef_m[i]) coef_m[i] = 0;
        samp_q.delete();
        start_sample(1);
        wait_result("post_reset_zero", N, 0, 32'h0);
        for (int k = 0; k < N; k++) cfg_write(k, k + 1);
        start_sample(1);
        wait_result("post_reset_hist", N, 0, 32'd3);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_symmetric();
        test_cfg_reject();
        test_wrap();
        test_same_edge();
        test_back_to_back();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
